// File: rtl/pack_build.sv
// Trace packet builder: takes 16-byte frames from an asynchronous front end over a
// 4-phase handshake and streams them out byte-wise. Optional macro: PACK_BUILD_IDLE_FILTER_EN.
module pack_build #(
   parameter int unsigned BUFPACKETS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         PkAvail,
   input  logic [127:0] Packet,
   output logic         PkAck,
   output logic [7:0]   DataVal,
   input  logic         DataNext,
   output logic         DataReady,
   output logic         DataOverf
);

   localparam int unsigned PW    = (BUFPACKETS > 1) ? $clog2(BUFPACKETS) : 1;
   localparam int unsigned BW    = PW + 4;
   localparam int unsigned OW    = BW + 1;
   localparam int unsigned DEPTH = 16 * BUFPACKETS;

   logic           pav_meta;
   logic           pav_s;
   logic [PW-1:0]  wr_ptr;
   logic [BW-1:0]  rd_ptr;
   logic [BW-1:0]  rd_n;
   logic [OW-1:0]  occ;
   logic [OW-1:0]  occ_n;
   logic [127:0]   mem [BUFPACKETS];
   logic           take;
   logic           pop;
   logic           room;
   logic           idle;
   logic           store;
   logic           drop;
   logic [127:0]   head_word;
   logic [7:0]     head_byte;

   // Take/pop decode and next head byte; a packet written this cycle is forwarded
   // when the new read pointer lands in its slot.
   always_comb begin
      take = pav_s & ~PkAck;
      pop  = DataNext & DataReady;
      room = (occ <= OW'(DEPTH - 16));
`ifdef PACK_BUILD_IDLE_FILTER_EN
      idle = (Packet == {8{16'h7FFF}});
`else
      idle = 1'b0;
`endif
      store = take & ~idle & room;
      drop  = take & ~idle & ~room;
      occ_n = occ;
      if (store) occ_n = occ_n + OW'(16);
      if (pop)   occ_n = occ_n - OW'(1);
      rd_n = rd_ptr + BW'(pop);
      if (store && (rd_n[BW-1:4] == wr_ptr)) head_word = Packet;
      else                                    head_word = mem[rd_n[BW-1:4]];
      head_byte = head_word[{rd_n[3:0], 3'b000} +: 8];
   end

   // Control state; PkAck simply follows the synchronised level one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         pav_meta  <= 1'b0;
         pav_s     <= 1'b0;
         PkAck     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         DataReady <= 1'b0;
         DataVal   <= 8'h00;
         DataOverf <= 1'b0;
      end else begin
         pav_meta  <= PkAvail;
         pav_s     <= pav_meta;
         PkAck     <= pav_s;
         if (store) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr    <= rd_n;
         occ       <= occ_n;
         DataReady <= (occ_n != '0);
         DataVal   <= (occ_n != '0) ? head_byte : 8'h00;
         if (drop)               DataOverf <= 1'b1;
         else if (occ_n == '0)   DataOverf <= 1'b0;
      end
   end

   // Packet storage, one 128-bit word per slot.
   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= Packet;
   end

endmodule

// File: tb/tb_pack_build.sv
// Directed self-checking bench for pack_build: handshake, byte order, overflow,
// pointer wrap, simultaneous take/pop, idle filter and mid-stream reset.
module tb_pack_build;

   logic         clk;
   logic         rst;
   logic         PkAvail;
   logic [127:0] Packet;
   logic         PkAck;
   logic [7:0]   DataVal;
   logic         DataNext;
   logic         DataReady;
   logic         DataOverf;

   int           n_checks;
   int           n_fail;
   logic [7:0]   q[$];
   logic [127:0] pkt;

   pack_build #(.BUFPACKETS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .PkAvail   (PkAvail),
      .Packet    (Packet),
      .PkAck     (PkAck),
      .DataVal   (DataVal),
      .DataNext  (DataNext),
      .DataReady (DataReady),
      .DataOverf (DataOverf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] make_pkt(input int seed);
      logic [127:0] p;
      for (int i = 0; i < 16; i++) p[8*i +: 8] = 8'(seed * 37 + i * 5);
      return p;
   endfunction

   task automatic push_bytes(input logic [127:0] p);
      for (int i = 0; i < 16; i++) q.push_back(p[8*i +: 8]);
   endtask

   // Bounded wait (called at a negedge) for PkAck to reach lvl.
   task automatic wait_ack(input logic lvl, input string tag);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (PkAck == lvl) break;
      end
      check(tag, 32'(PkAck), 32'(lvl));
   endtask

   task automatic send_packet(input logic [127:0] p, input logic stored);
      Packet  = p;
      PkAvail = 1'b1;
      wait_ack(1'b1, "ack_rise");
      PkAvail = 1'b0;
      wait_ack(1'b0, "ack_fall");
      if (stored) push_bytes(p);
   endtask

   // Pops n bytes back to back, checking each head against the model queue.
   task automatic drain(input int n);
      logic [7:0] exp;
      for (int i = 0; i < n; i++) begin
         exp = (q.size() > 0) ? q.pop_front() : 8'h00;
         check("drain_rdy", 32'(DataReady), 32'd1);
         check("drain_val", 32'(DataVal), 32'(exp));
         DataNext = 1'b1;
         @(negedge clk);
      end
      DataNext = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      PkAvail  = 1'b0;
      Packet   = '0;
      DataNext = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack",   32'(PkAck),     32'd0);
      check("rst_rdy",   32'(DataReady), 32'd0);
      check("rst_val",   32'(DataVal),   32'd0);
      check("rst_overf", 32'(DataOverf), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single packet, byte i = i, with latency bound on DataReady.
      pkt     = 128'h0F0E0D0C0B0A09080706050403020100;
      Packet  = pkt;
      PkAvail = 1'b1;
      repeat (5) @(negedge clk);
      check("lat_rdy", 32'(DataReady), 32'd1);
      check("lat_ack", 32'(PkAck),     32'd1);
      check("lat_val", 32'(DataVal),   32'h00);
      PkAvail = 1'b0;
      wait_ack(1'b0, "single_ack_fall");
      push_bytes(pkt);
      drain(16);
      check("single_empty", 32'(DataReady), 32'd0);
      check("single_val0",  32'(DataVal),   32'd0);
      check("single_overf", 32'(DataOverf), 32'd0);

      // Fill: eight stored, ninth dropped.
      for (int p = 0; p < 8; p++) send_packet(make_pkt(p), 1'b1);
      check("fill_no_overf", 32'(DataOverf), 32'd0);
      send_packet(make_pkt(8), 1'b0);
      check("fill_overf", 32'(DataOverf), 32'd1);
      drain(127);
      check("fill_overf_hold", 32'(DataOverf), 32'd1);
      drain(1);
      check("fill_overf_clr", 32'(DataOverf), 32'd0);
      check("fill_empty",     32'(DataReady), 32'd0);

      // Wrap: twenty packets interleaved with full drains.
      for (int r = 0; r < 10; r++) begin
         send_packet(make_pkt(20 + 2 * r), 1'b1);
         send_packet(make_pkt(21 + 2 * r), 1'b1);
         drain(32);
      end
      check("wrap_empty", 32'(DataReady), 32'd0);

      // Simultaneous take and pop at occupancy 5 -> 20.
      send_packet(make_pkt(100), 1'b1);
      drain(9);
      pkt      = make_pkt(101);
      Packet   = pkt;
      push_bytes(pkt);
      PkAvail  = 1'b1;
      DataNext = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("simul_val", 32'(DataVal), 32'(q.pop_front()));
         @(negedge clk);
      end
      DataNext = 1'b0;
      check("simul_ack", 32'(PkAck), 32'd1);
      PkAvail = 1'b0;
      wait_ack(1'b0, "simul_ack_fall");
      drain(20);
      check("simul_empty", 32'(DataReady), 32'd0);

      // Idle frame.
`ifdef PACK_BUILD_IDLE_FILTER_EN
      send_packet({8{16'h7FFF}}, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_filtered", 32'(DataReady), 32'd0);
`else
      send_packet({8{16'h7FFF}}, 1'b1);
      drain(16);
`endif
      check("idle_empty", 32'(DataReady), 32'd0);
      check("idle_overf", 32'(DataOverf), 32'd0);

      // Reset after three pops.
      send_packet(make_pkt(200), 1'b1);
      drain(3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_rdy", 32'(DataReady), 32'd0);
      check("mid_rst_val", 32'(DataVal),   32'd0);
      check("mid_rst_ack", 32'(PkAck),     32'd0);
      q.delete();

      // Reset mid-handshake with PkAvail still high: retaken once.
      pkt     = make_pkt(201);
      Packet  = pkt;
      PkAvail = 1'b1;
      wait_ack(1'b1, "hs_ack_rise");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("hs_rst_ack", 32'(PkAck),     32'd0);
      check("hs_rst_rdy", 32'(DataReady), 32'd0);
      push_bytes(pkt);
      wait_ack(1'b1, "hs_retake");
      PkAvail = 1'b0;
      wait_ack(1'b0, "hs_ack_fall");
      drain(16);
      check("hs_empty", 32'(DataReady), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pack_build.md
PACK_BUILD -- requirements
Module: pack_build

Interface
REQ-001 Parameter BUFPACKETS, default 8: buffer depth in 16-byte packets; power of two, at least 2.
REQ-002 clk  input  1  system clock; the single clock of the block.
REQ-003 rst  input  1  reset; synchronous to clk and active-high.
REQ-004 PkAvail  input  1  packet-available level from the trace-port front end; asynchronous to clk.
REQ-005 Packet  input  128  frame from the front end; stable while PkAvail is high.
REQ-006 PkAck  output  1  packet acknowledge level back to the front end.
REQ-007 DataVal  output  8  current head byte of the buffer.
REQ-008 DataNext  input  1  consumer pop request; one byte per high clk cycle.
REQ-009 DataReady  output  1  buffer holds at least one byte; DataVal is valid.
REQ-010 DataOverf  output  1  sticky overflow flag; a packet was dropped.

Function
REQ-011 PkAvail SHALL pass through a 2-flop synchroniser (pav_s) before any use.
REQ-012 Input handshake is 4-phase: a packet is taken when pav_s=1 and PkAck=0.
REQ-013 On that take cycle the block SHALL store Packet into the buffer (if not dropped) and set PkAck=1 on the next edge.
REQ-014 PkAck SHALL stay 1 while pav_s=1 and return to 0 the first cycle after pav_s=0.
REQ-015 Exactly one packet SHALL be taken per PkAvail high phase.
REQ-016 Byte order: Packet[7:0] is emitted first, then Packet[15:8], and so on up to Packet[127:120] last.
REQ-017 Storage is a circular buffer of 16*BUFPACKETS bytes: write pointer advances per packet, read pointer per byte, both wrap modulo size.
REQ-018 Occupancy is tracked in bytes, 0..16*BUFPACKETS.
REQ-019 A take with fewer than 16 free bytes SHALL drop the packet, leave pointers unchanged, set DataOverf=1, and still complete the PkAck handshake.
REQ-020 DataOverf SHALL remain 1 until reset or until occupancy reaches 0.
REQ-021 DataReady = (occupancy != 0), registered.
REQ-022 DataVal SHALL be the byte at the read pointer when DataReady=1, and 8'h00 otherwise.
REQ-023 DataNext=1 with DataReady=1 SHALL pop one byte; DataVal/DataReady reflect the new head on the next cycle.
REQ-024 DataNext with DataReady=0 SHALL be ignored.
REQ-025 A take and a pop in the same cycle are both performed: occupancy += 16-1.
REQ-026 Free-space check uses occupancy before the same-cycle pop.
REQ-027 Latency: with an empty buffer, DataReady SHALL rise no later than 5 clk after PkAvail rises.
REQ-028 Sustained throughput: one pop per clk with no bubbles while data is present.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL clear pointers and occupancy, the synchroniser, PkAck, DataReady and DataOverf.
REQ-030 DataVal reads 8'h00 after reset.
REQ-031 A packet mid-handshake at reset is discarded.
REQ-032 After reset, a still-high PkAvail is taken once as a new packet.

Configuration
REQ-033 Macro PACK_BUILD_IDLE_FILTER_EN defined: a taken packet whose eight 16-bit halfwords all equal 16'h7FFF (TPIU idle/half-sync) is acknowledged but neither stored nor counted as overflow.
REQ-034 Macro absent: every taken packet is stored under REQ-019 rules.

Verification
REQ-035 Single packet: Packet=128'h0F0E...0100 (byte i = i), PkAvail pulse -> PkAck handshakes once; DataNext held high yields DataVal 00,01,...,0F; DataReady drops after the 16th pop.
REQ-036 Fill: BUFPACKETS=8, 9 packets, no pops -> first 8 stored, 9th dropped, DataOverf=1; draining 128 bytes returns DataOverf to 0 at empty.
REQ-037 Wrap: 20 packets interleaved with full drains -> all 320 bytes emitted in order across the pointer wrap.
REQ-038 Simultaneous: packet taken on the same cycle as a pop with occupancy 5 -> occupancy 20, no byte lost or duplicated.
REQ-039 Idle filter: all-7FFF packet -> PkAck completes; DataReady stays 0 with the macro defined, 16 bytes of 7F/FF appear without it.
REQ-040 Reset mid-stream: rst after 3 of 16 pops -> DataReady=0, DataVal=00, PkAck=0 next cycle; the next packet is emitted from byte 0.
